dspl_scan_decoder: RTL

//  Receive side of the 8-digit multiplexed 7-segment bus (an / dec_ddp) driven by the display driver.

---
 rtl/dspl_scan_decoder_pkg.sv | 31 +++
 rtl/dspl_scan_decoder_seg7_to_hex.sv | 27 ++
 rtl/dspl_scan_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dspl_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: digit count, glyph table, FSM states.
// The glyph table is the same one the display driver uses to light the segments.
package dspl_scan_decoder_pkg;

    localparam int N_DIG = 8;

    // Active-low segments ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_t;

    function automatic logic [2:0] onehot_index(input logic [N_DIG-1:0] sel);
        logic [2:0] result;
        result = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (sel[i]) begin
                result = 3'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dspl_scan_decoder_seg7_to_hex.sv
// Combinational glyph decoder: active-low segment pattern back to a hex nibble.
// Blank reads as 0 without an error; any other unknown pattern raises bad and reads as 0.
module seg7_to_hex
    import dspl_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       blank,
    output logic       bad
);

    logic match;

    always_comb begin
        hex   = '0;
        match = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (seg == SEG_HEX[k]) begin
                hex   = 4'(k);
                match = 1'b1;
            end
        end
        blank = (seg == SEG_BLANK);
        bad   = !match && !blank;
    end

endmodule

// File: rtl/dspl_scan_decoder.sv
// Receive side of the multiplexed 8-digit display bus: rebuilds one 32-bit hex frame per scan.
// Optional build macro DSPL_SCAN_PARITY_EN adds a registered XOR-parity output over the published digits.
module dspl_scan_decoder
    import dspl_scan_decoder_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65536
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DIG-1:0]   an,
    input  logic [7:0]         dec_ddp,
    output logic               frame_valid,
    output logic [4*N_DIG-1:0] digits,
    output logic [N_DIG-1:0]   dp_o,
    output logic [N_DIG-1:0]   present,
    output logic               seg_err,
    output logic               an_err
`ifdef DSPL_SCAN_PARITY_EN
    ,
    output logic               parity
`endif
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    scan_state_t state, state_nxt;

    logic [2:0]         cur;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      tcnt, tcnt_nxt;
    logic [4*N_DIG-1:0] acc_digits, acc_digits_nxt;
    logic [N_DIG-1:0]   acc_dp, acc_dp_nxt;
    logic [N_DIG-1:0]   acc_present, acc_present_nxt;

    logic [N_DIG-1:0] sel;
    logic             any_sel, one_sel, multi_sel, same_sel;
    logic [2:0]       idx;
    logic             restart, settle_inc, capture, timeout, publish;

    logic [3:0] dec_hex;
    logic       dec_blank, dec_bad;

    seg7_to_hex u_seg7_to_hex (
        .seg   (dec_ddp[7:1]),
        .hex   (dec_hex),
        .blank (dec_blank),
        .bad   (dec_bad)
    );

    assign sel       = ~an;
    assign any_sel   = |sel;
    assign one_sel   = any_sel && ((sel & (sel - 1'b1)) == '0);
    assign multi_sel = any_sel && !one_sel;
    assign idx       = onehot_index(sel);
    assign same_sel  = one_sel && (idx == cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new anode (from any state) restarts the settle window; a collision drops everything
    always_comb begin
        state_nxt  = state;
        restart    = 1'b0;
        settle_inc = 1'b0;
        capture    = 1'b0;
        if (!one_sel) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   restart = 1'b1;
                ST_SETTLE: begin
                    if (!same_sel) begin
                        restart = 1'b1;
                    end else if (cnt == CW'(SETTLE_CYC - 1)) begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        settle_inc = 1'b1;
                    end
                end
                ST_HOLD:   restart = !same_sel;
                default:   restart = 1'b1;
            endcase
            if (restart) begin
                if (SETTLE_CYC <= 1) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
        end
    end

    // A repeated position closes the current frame before the new digit opens the next one
    always_comb begin
        tcnt_nxt = '0;
        if (state == ST_IDLE && !any_sel) begin
            tcnt_nxt = (tcnt == TW'(TIMEOUT_CYC)) ? tcnt : tcnt + 1'b1;
        end
        timeout = (state == ST_IDLE) && !any_sel && (tcnt == TW'(TIMEOUT_CYC - 1))
                  && (|acc_present);
        publish = timeout || (capture && acc_present[idx]);

        acc_digits_nxt  = publish ? '0 : acc_digits;
        acc_dp_nxt      = publish ? '0 : acc_dp;
        acc_present_nxt = publish ? '0 : acc_present;
        if (capture) begin
            acc_digits_nxt[{idx, 2'b00} +: 4] = dec_blank ? 4'h0 : dec_hex;
            acc_dp_nxt[idx]                   = ~dec_ddp[0];
            acc_present_nxt[idx]              = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= '0;
            cnt         <= '0;
            tcnt        <= '0;
            acc_digits  <= '0;
            acc_dp      <= '0;
            acc_present <= '0;
            frame_valid <= 1'b0;
            digits      <= '0;
            dp_o        <= '0;
            present     <= '0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            if (restart) begin
                cur <= idx;
                cnt <= CW'(1);
            end else if (settle_inc) begin
                cnt <= cnt + 1'b1;
            end
            tcnt        <= tcnt_nxt;
            acc_digits  <= acc_digits_nxt;
            acc_dp      <= acc_dp_nxt;
            acc_present <= acc_present_nxt;
            frame_valid <= publish;
            if (publish) begin
                digits  <= acc_digits;
                dp_o    <= acc_dp;
                present <= acc_present;
            end
            // Stays up through the frame_valid pulse so the bad frame is flagged
            if (capture && dec_bad) begin
                seg_err <= 1'b1;
            end else if (frame_valid) begin
                seg_err <= 1'b0;
            end
            an_err <= multi_sel;
        end
    end

`ifdef DSPL_SCAN_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (publish) begin
            parity <= ^acc_digits;
        end
    end
`endif

endmodule
